alu_arbiter: RTL and testbench

- Shares one `alu` instance between NUM_REQ requesters using round-robin arbitration.
- Each requester presents operands and an `isa_defs_pkg::alu_op_e` opcode on a valid/ready port.
- The winner's operation is computed and captured in a single-entry response register, tagged with the requester ID.
- Sits between the issue logic (or multiple functional-unit clients) and the shared ALU.

---
 rtl/alu_arbiter.sv | 228 ++++++++++++++++++++++
 tb/tb_alu_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter -- shares one combinational ALU among NUM_REQ requesters using
// round-robin arbitration. The winning request is computed in the same cycle
// and captured in a single-entry response register, tagged with the winner's
// index.
//
// Contents (package first, then sub-module, then top):
//   isa_defs_pkg : ALU opcode enumeration.
//   alu          : 32-bit combinational ALU (ADD, SUB; any other op gives 0).
//   alu_arbiter  : round-robin arbiter and response register.
//
// alu_arbiter ports:
//   clk          in   clock; all state changes on the rising edge
//   rst_n        in   synchronous active-low reset
//   req_valid    in   [NUM_REQ]        per-requester request valid
//   req_ready    out  [NUM_REQ]        per-requester accept, at most one hot
//   req_a        in   [NUM_REQ*32]     operand A, requester i at [32*i +: 32]
//   req_b        in   [NUM_REQ*32]     operand B, same packing
//   req_op       in   [NUM_REQ] alu_op_e  opcode per requester
//   rsp_valid    out  response register holds a result
//   rsp_ready    in   consumer accepts the response
//   rsp_id       out  [ID_W]  requester that owns the response
//   rsp_result   out  [32]    ALU result
//
// Optional build macro ALU_ARBITER_STATS_EN adds:
//   grant_count  out  [NUM_REQ*16]  saturating per-requester transfer counters
//   stall_cycles out  [16]          saturating count of cycles with a request
//                                   pending and no transfer
// -----------------------------------------------------------------------------

package isa_defs_pkg;

    typedef enum logic [1:0] {
        ALU_OP_NOP  = 2'd0,
        ALU_OP_ADD  = 2'd1,
        ALU_OP_SUB  = 2'd2,
        ALU_OP_RSVD = 2'd3
    } alu_op_e;

endpackage : isa_defs_pkg

// Combinational 32-bit ALU. Arithmetic wraps modulo 2^32.
module alu
    import isa_defs_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  alu_op_e     op,
    output logic [31:0] result
);

    // NOTE: every signal written in always_comb gets a default on entry;
    // a path that leaves it unassigned would infer a latch.
    always_comb begin
        result = '0;
        case (op)
            ALU_OP_ADD: result = a + b;
            ALU_OP_SUB: result = a - b;
            default:    result = '0;
        endcase
    end

endmodule : alu

module alu_arbiter
    import isa_defs_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [32*NUM_REQ-1:0]   req_a,
    input  logic [32*NUM_REQ-1:0]   req_b,
    input  alu_op_e [NUM_REQ-1:0]   req_op,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [31:0]             rsp_result
`ifdef ALU_ARBITER_STATS_EN
    ,
    output logic [16*NUM_REQ-1:0]   grant_count,
    output logic [15:0]             stall_cycles
`endif
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } rsp_state_e;

    rsp_state_e        state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic [31:0]       rsp_result_q, rsp_result_d;

    logic              slot_free;
    logic              grant_any;
    logic [ID_W-1:0]   grant_idx;
    logic [NUM_REQ-1:0] grant_oh;

    logic [31:0]       alu_a, alu_b, alu_result;
    alu_op_e           alu_op;

    // -------------------------------------------------------------------------
    // Round-robin grant. The slot is free when empty or when the held response
    // drains this cycle, so drain and accept can share a cycle. The scan starts
    // at the pointer and wraps; the first valid requester wins. Gating with
    // rst_n keeps req_ready low for the whole reset cycle, so a requester never
    // sees an accept for a request that will be discarded.
    // -------------------------------------------------------------------------
    always_comb begin
        int idx;
        idx       = 0;
        slot_free = (state_q == ST_EMPTY) || rsp_ready;
        grant_any = 1'b0;
        grant_idx = '0;
        grant_oh  = '0;
        if (slot_free && rst_n) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = int'(ptr_q) + k;
                if (idx >= NUM_REQ) begin
                    idx = idx - NUM_REQ;
                end
                if (!grant_any && req_valid[idx]) begin
                    grant_any     = 1'b1;
                    grant_idx     = ID_W'(idx);
                    grant_oh[idx] = 1'b1;
                end
            end
        end
    end

    assign req_ready = grant_oh;

    // Operand mux feeding the single shared ALU.
    assign alu_a  = req_a[32*grant_idx +: 32];
    assign alu_b  = req_b[32*grant_idx +: 32];
    assign alu_op = req_op[grant_idx];

    alu u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .op     (alu_op),
        .result (alu_result)
    );

    // -------------------------------------------------------------------------
    // Next-state logic. A transfer always wins over a drain: the register is
    // overwritten and stays FULL. The pointer only moves on a transfer.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        if (grant_any) begin
            state_d      = ST_FULL;
            rsp_id_d     = grant_idx;
            rsp_result_d = alu_result;
            ptr_d        = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0
                                                             : grant_idx + ID_W'(1);
        end else if ((state_q == ST_FULL) && rsp_ready) begin
            state_d = ST_EMPTY;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples its _d value from before the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_EMPTY;
            ptr_q        <= '0;
            rsp_id_q     <= '0;
            // NOTE: the result register is a plain data register, but it is
            // reset so rsp_result reads 0 after reset instead of X.
            rsp_result_q <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
        end
    end

    assign rsp_valid  = (state_q == ST_FULL);
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;

`ifdef ALU_ARBITER_STATS_EN
    // -------------------------------------------------------------------------
    // Saturating statistics counters.
    // -------------------------------------------------------------------------
    logic [NUM_REQ-1:0][15:0] grant_count_q, grant_count_d;
    logic [15:0]              stall_cycles_q, stall_cycles_d;

    always_comb begin
        grant_count_d  = grant_count_q;
        stall_cycles_d = stall_cycles_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_oh[i] && (grant_count_q[i] != 16'hFFFF)) begin
                grant_count_d[i] = grant_count_q[i] + 16'd1;
            end
        end
        if ((|req_valid) && !grant_any && (stall_cycles_q != 16'hFFFF)) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant_count_q  <= '0;
            stall_cycles_q <= '0;
        end else begin
            grant_count_q  <= grant_count_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign grant_count  = grant_count_q;
    assign stall_cycles = stall_cycles_q;
`else
    // Statistics disabled: no counter logic is built.
`endif

endmodule : alu_arbiter

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter -- self-checking bench for alu_arbiter (NUM_REQ = 4).
// Directed sequences cover reset, single request, round-robin order,
// back-pressure with same-cycle drain/accept, and reset mid-operation; a
// table of single-request vectors covers the arithmetic edges. The stats
// sequence is compiled in when ALU_ARBITER_STATS_EN is defined.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// on the falling edge.
// -----------------------------------------------------------------------------

module tb_alu_arbiter;
    import isa_defs_pkg::*;

    localparam int N = 4;

    logic              clk;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [32*N-1:0]   req_a;
    logic [32*N-1:0]   req_b;
    alu_op_e [N-1:0]   req_op;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_id;
    logic [31:0]       rsp_result;
`ifdef ALU_ARBITER_STATS_EN
    logic [16*N-1:0]   grant_count;
    logic [15:0]       stall_cycles;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    alu_arbiter #(.NUM_REQ(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result)
`ifdef ALU_ARBITER_STATS_EN
        ,
        .grant_count  (grant_count),
        .stall_cycles (stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        alu_op_e     op;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input alu_op_e op);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
        req_op[i]         = op;
    endtask

    initial begin
        vecs[0] = '{2, 32'h0000_0000, 32'h0000_0001, ALU_OP_SUB,  32'hFFFF_FFFF};
        vecs[1] = '{3, 32'hFFFF_FFFF, 32'h0000_0001, ALU_OP_ADD,  32'h0000_0000};
        vecs[2] = '{1, 32'h0000_0007, 32'h0000_0009, ALU_OP_NOP,  32'h0000_0000};
        vecs[3] = '{0, 32'h0000_000A, 32'h0000_0003, ALU_OP_SUB,  32'h0000_0007};
        vecs[4] = '{1, 32'h7FFF_FFFF, 32'h0000_0001, ALU_OP_ADD,  32'h8000_0000};
        vecs[5] = '{3, 32'h0000_000C, 32'h0000_0022, ALU_OP_RSVD, 32'h0000_0000};

        // ---------------- reset: requests pending must not be accepted -------
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        rsp_ready = 1'b0;
        req_a     = '0;
        req_b     = '0;
        for (int i = 0; i < N; i++) req_op[i] = ALU_OP_NOP;
        step();
        step();
        @(negedge clk);
        check("reset_req_ready",  32'(req_ready),  32'h0);
        check("reset_rsp_valid",  32'(rsp_valid),  32'h0);
        check("reset_rsp_id",     32'(rsp_id),     32'h0);
        check("reset_rsp_result", rsp_result,      32'h0);
        step();
        rst_n     = 1'b1;
        req_valid = '0;

        // ---------------- single request: 5 + 3 ------------------------------
        set_req(0, 32'd5, 32'd3, ALU_OP_ADD);
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("single_req_ready", 32'(req_ready), 32'h1);
        step();
        req_valid = '0;
        @(negedge clk);
        check("single_rsp_valid",  32'(rsp_valid), 32'h1);
        check("single_rsp_id",     32'(rsp_id),    32'h0);
        check("single_rsp_result", rsp_result,     32'd8);

        // Reset again so the pointer restarts at requester 0.
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;

        // ---------------- round-robin with all requesters valid --------------
        for (int i = 0; i < N; i++) set_req(i, 32'(100 + i), 32'(i), ALU_OP_ADD);
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("rr_req_ready", 32'(req_ready), 32'(1 << (k % 4)));
            if (k > 0) begin
                check("rr_rsp_id",     32'(rsp_id), 32'((k - 1) % 4));
                check("rr_rsp_result", rsp_result,  32'(100 + 2 * ((k - 1) % 4)));
            end
            step();
        end

        // ---------------- back-pressure: response from requester 1 held ------
        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_req_ready",  32'(req_ready), 32'h0);
            check("bp_rsp_valid",  32'(rsp_valid), 32'h1);
            check("bp_rsp_id",     32'(rsp_id),    32'h1);
            check("bp_rsp_result", rsp_result,     32'd102);
            step();
        end
        // Release: drain and accept requester 2 in the same cycle.
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 32'(req_ready), 32'b0100);
        step();
        req_valid = '0;
        @(negedge clk);
        check("bp_next_valid",  32'(rsp_valid), 32'h1);
        check("bp_next_id",     32'(rsp_id),    32'h2);
        check("bp_next_result", rsp_result,     32'd104);
        step();
        @(negedge clk);
        check("drain_rsp_valid", 32'(rsp_valid), 32'h0);
        step();

        // ---------------- arithmetic edge vectors ----------------------------
        for (int v = 0; v < 6; v++) begin
            set_req(vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].op);
            req_valid = 4'(1 << vecs[v].id);
            @(negedge clk);
            check("vec_req_ready", 32'(req_ready), 32'(1 << vecs[v].id));
            step();
            req_valid = '0;
            @(negedge clk);
            check("vec_rsp_valid",  32'(rsp_valid), 32'h1);
            check("vec_rsp_id",     32'(rsp_id),    32'(vecs[v].id));
            check("vec_rsp_result", rsp_result,     vecs[v].exp);
            step();
        end

        // ---------------- reset mid-operation --------------------------------
        set_req(2, 32'd1, 32'd1, ALU_OP_ADD);
        req_valid = 4'b0100;
        rsp_ready = 1'b0;
        @(negedge clk);
        check("mid_req_ready", 32'(req_ready), 32'b0100);
        step();
        req_valid = '0;
        @(negedge clk);
        check("mid_full_valid",  32'(rsp_valid), 32'h1);
        check("mid_full_id",     32'(rsp_id),    32'h2);
        check("mid_full_result", rsp_result,     32'd2);
        step();
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        set_req(0, 32'd20, 32'd5, ALU_OP_SUB);
        @(negedge clk);
        check("mid_rst_req_ready", 32'(req_ready), 32'h0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_post_rst_valid", 32'(rsp_valid), 32'h0);
        check("mid_post_rst_ready", 32'(req_ready), 32'b0001);
        step();
        req_valid = '0;
        @(negedge clk);
        check("mid_first_valid",  32'(rsp_valid), 32'h1);
        check("mid_first_id",     32'(rsp_id),    32'h0);
        check("mid_first_result", rsp_result,     32'd15);
        step();

`ifdef ALU_ARBITER_STATS_EN
        // ---------------- statistics counters --------------------------------
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        step();
        rst_n = 1'b1;
        set_req(1, 32'd1, 32'd1, ALU_OP_ADD);
        req_valid = 4'b0010;
        repeat (10) step();
        rsp_ready = 1'b0;
        repeat (4) step();
        req_valid = '0;
        @(negedge clk);
        check("stats_gc0",   32'(grant_count[15:0]),  32'd0);
        check("stats_gc1",   32'(grant_count[31:16]), 32'd10);
        check("stats_gc2",   32'(grant_count[47:32]), 32'd0);
        check("stats_gc3",   32'(grant_count[63:48]), 32'd0);
        check("stats_stall", 32'(stall_cycles),       32'd4);
        step();
        rsp_ready = 1'b1;
        req_valid = 4'b0010;
        repeat (70000) step();
        req_valid = '0;
        @(negedge clk);
        check("stats_gc1_sat",   32'(grant_count[31:16]), 32'hFFFF);
        check("stats_stall_end", 32'(stall_cycles),       32'd4);
        step();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_alu_arbiter
